// File: rtl/alu_if_pkg.sv
// Shared types and constants for the ALU operand-interface initiator.
// States, split encodings, multiply commands and RSP_FLAGS bit positions.
package alu_if_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_GAP    = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam logic [1:0] SPLIT_BOTH = 2'd0;
  localparam logic [1:0] SPLIT_AB   = 2'd1;
  localparam logic [1:0] SPLIT_BA   = 2'd2;
  localparam logic [1:0] SPLIT_RSVD = 2'd3;

  localparam int CMD_MUL_INC = 9;
  localparam int CMD_MUL_SHL = 10;

  localparam int FLG_ERR   = 0;
  localparam int FLG_L     = 1;
  localparam int FLG_E     = 2;
  localparam int FLG_G     = 3;
  localparam int FLG_OFLOW = 4;
  localparam int FLG_COUT  = 5;

  // The reserved split code behaves like "both together".
  function automatic logic [1:0] norm_split(
    input logic [1:0] s
  );
    return (s == SPLIT_RSVD) ? SPLIT_BOTH : s;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter shared by the GAP and WAIT phases.
// Ports: CLK, RST_N (sync, active-low), load/load_val, dec, last (count==1).
module alu_lat_counter #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/alu_op_issuer.sv
// Drives one ALU operation per request (operands together or split
// with an idle gap), then captures RES/flags and returns them on RSP.
// Ports: CLK, RST_N; REQ_* upstream valid/ready; INP_VALID/OPA/OPB/
// CMD/MODE/CIN/CE to the ALU; RES + flags from the ALU; RSP_* downstream.
module alu_op_issuer
  import alu_if_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int GW      = 5,
  parameter int RES_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int TMO     = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [DW-1:0] REQ_OPA,
  input  logic [DW-1:0] REQ_OPB,
  input  logic [CW-1:0] REQ_CMD,
  input  logic          REQ_MODE,
  input  logic          REQ_CIN,
  input  logic [1:0]    REQ_SPLIT,
  input  logic [GW-1:0] REQ_GAP,
  output logic [1:0]    INP_VALID,
  output logic [DW-1:0] OPA,
  output logic [DW-1:0] OPB,
  output logic [CW-1:0] CMD,
  output logic          MODE,
  output logic          CIN,
  output logic          CE,
  input  logic [DW+1:0] RES,
  input  logic          COUT,
  input  logic          OFLOW,
  input  logic          G,
  input  logic          E,
  input  logic          L,
  input  logic          ERR,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW+1:0] RSP_RES,
  output logic [5:0]    RSP_FLAGS,
  output logic          RSP_TMO
);

  state_e        state_q, state_d;
  logic [DW-1:0] opa_q, opb_q;
  logic [DW-1:0] opa_hold_q, opb_hold_q;
  logic [CW-1:0] cmd_q;
  logic          mode_q, cin_q;
  logic [1:0]    split_q, split_in;
  logic [GW-1:0] gap_q;
  logic          tmo_q;
  logic [DW+1:0] res_q;
  logic [5:0]    flags_q, flags_in;
  logic          accept, capture;
  logic          cnt_load, cnt_dec, cnt_last;
  logic [GW-1:0] cnt_val, lat_val;
  logic          is_mul;
  logic          drive_a, drive_b;

  assign is_mul = mode_q &&
    ((cmd_q == CW'(CMD_MUL_INC)) ||
     (cmd_q == CW'(CMD_MUL_SHL)));
  assign lat_val = is_mul ? GW'(MUL_LAT)
                          : GW'(RES_LAT);
  assign split_in = norm_split(REQ_SPLIT);

  alu_lat_counter #(.W(GW)) u_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          accept  = 1'b1;
          state_d = S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        cnt_load = 1'b1;
        if (split_q == SPLIT_BOTH) begin
          cnt_val = lat_val;
          state_d = S_WAIT;
        end else if (gap_q != '0) begin
          cnt_val = gap_q;
          state_d = S_GAP;
        end else begin
          state_d = S_ISSUE2;
        end
      end
      S_GAP: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = S_ISSUE2;
        end
      end
      S_ISSUE2: begin
        cnt_load = 1'b1;
        cnt_val  = lat_val;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drive_a   = 1'b0;
    drive_b   = 1'b0;
    CE        = 1'b0;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        REQ_READY = RST_N;
      end
      (state_q == S_ISSUE1): begin
        CE      = 1'b1;
        drive_a = (split_q != SPLIT_BA);
        drive_b = (split_q != SPLIT_AB);
      end
      (state_q == S_GAP): begin
        CE = 1'b1;
      end
      (state_q == S_ISSUE2): begin
        CE      = 1'b1;
        drive_a = (split_q == SPLIT_BA);
        drive_b = (split_q == SPLIT_AB);
      end
      (state_q == S_WAIT): begin
        CE = 1'b1;
      end
      (state_q == S_RESP): begin
        RSP_VALID = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand buses keep their last driven value when not issuing.
  assign INP_VALID = {drive_b, drive_a};
  assign OPA  = drive_a ? opa_q : opa_hold_q;
  assign OPB  = drive_b ? opb_q : opb_hold_q;
  assign CMD  = cmd_q;
  assign MODE = mode_q;
  assign CIN  = cin_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      opa_hold_q <= '0;
      opb_hold_q <= '0;
    end else begin
      opa_hold_q <= OPA;
      opb_hold_q <= OPB;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      split_q <= SPLIT_BOTH;
      gap_q   <= '0;
      tmo_q   <= 1'b0;
    end else if (accept) begin
      opa_q   <= REQ_OPA;
      opb_q   <= REQ_OPB;
      cmd_q   <= REQ_CMD;
      mode_q  <= REQ_MODE;
      cin_q   <= REQ_CIN;
      split_q <= split_in;
      gap_q   <= REQ_GAP;
      tmo_q   <= (split_in != SPLIT_BOTH) &&
                 (REQ_GAP >= GW'(TMO));
    end
  end

  always_comb begin
    flags_in            = '0;
    flags_in[FLG_COUT]  = COUT;
    flags_in[FLG_OFLOW] = OFLOW;
    flags_in[FLG_G]     = G;
    flags_in[FLG_E]     = E;
    flags_in[FLG_L]     = L;
    flags_in[FLG_ERR]   = ERR;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      res_q   <= '0;
      flags_q <= '0;
    end else if (capture) begin
      res_q   <= RES;
      flags_q <= flags_in;
    end
  end

  assign RSP_RES   = res_q;
  assign RSP_FLAGS = flags_q;
  assign RSP_TMO   = tmo_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a small behavioural ALU.
// Table of operations plus reset and backpressure sequences.
module tb_alu_op_issuer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [7:0] REQ_OPA = '0;
  logic [7:0] REQ_OPB = '0;
  logic [3:0] REQ_CMD = '0;
  logic       REQ_MODE = 1'b0;
  logic       REQ_CIN = 1'b0;
  logic [1:0] REQ_SPLIT = '0;
  logic [4:0] REQ_GAP = '0;
  logic [1:0] INP_VALID;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN, CE;
  logic [9:0] RES;
  logic       COUT, OFLOW, G, E, L, ERR;
  logic       RSP_VALID;
  logic       RSP_READY = 1'b0;
  logic [9:0] RSP_RES;
  logic [5:0] RSP_FLAGS;
  logic       RSP_TMO;

  int checks = 0;
  int errors = 0;

  alu_op_issuer dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB),
    .REQ_CMD(REQ_CMD), .REQ_MODE(REQ_MODE),
    .REQ_CIN(REQ_CIN), .REQ_SPLIT(REQ_SPLIT),
    .REQ_GAP(REQ_GAP),
    .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB),
    .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
    .G(G), .E(E), .L(L), .ERR(ERR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
    .RSP_TMO(RSP_TMO)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU: latches operands as they are issued.
  logic [7:0] a_l = '0;
  logic [7:0] b_l = '0;
  logic [8:0] sum9;
  logic       alu_err = 1'b0;

  always @(posedge CLK) begin
    if (CE && INP_VALID[0]) a_l <= OPA;
    if (CE && INP_VALID[1]) b_l <= OPB;
  end

  always_comb begin
    RES  = '0;
    COUT = 1'b0;
    sum9 = {1'b0, a_l} + {1'b0, b_l} + {8'd0, CIN};
    if (MODE) begin
      case (CMD)
        4'd0: begin
          RES  = {2'b00, sum9[7:0]};
          COUT = sum9[8];
        end
        4'd9:  RES = ({2'b00, a_l} + 10'd1) *
                     ({2'b00, b_l} + 10'd1);
        4'd10: RES = ({2'b00, a_l} << 1) *
                     {2'b00, b_l};
        default: RES = '0;
      endcase
    end else begin
      case (CMD)
        4'd0: RES = {2'b00, a_l & b_l};
        4'd1: RES = {2'b00, a_l | b_l};
        4'd2: RES = {2'b00, a_l ^ b_l};
        default: RES = '0;
      endcase
    end
  end

  assign OFLOW = 1'b0;
  assign G   = a_l > b_l;
  assign E   = a_l == b_l;
  assign L   = a_l < b_l;
  assign ERR = alu_err;

  typedef struct {
    logic [1:0] split;
    logic [4:0] gap;
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       err;
    logic [9:0] res;
    logic [5:0] flags;
    logic       tmo;
    int         cyc;
    int         idle;
    logic [1:0] iv1;
    logic [1:0] iv2;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(
    input logic [1:0] split, input logic [4:0] gap,
    input logic mode, input logic [3:0] cmd,
    input logic cin, input logic [7:0] a,
    input logic [7:0] b, input logic err,
    input logic [9:0] res, input logic [5:0] flags,
    input logic tmo, input int cyc, input int idle,
    input logic [1:0] iv1, input logic [1:0] iv2
  );
    vec_t v;
    v.split = split; v.gap = gap; v.mode = mode;
    v.cmd = cmd; v.cin = cin; v.a = a; v.b = b;
    v.err = err; v.res = res; v.flags = flags;
    v.tmo = tmo; v.cyc = cyc; v.idle = idle;
    v.iv1 = iv1; v.iv2 = iv2;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic set_req(input vec_t v);
    REQ_OPA   = v.a;
    REQ_OPB   = v.b;
    REQ_CMD   = v.cmd;
    REQ_MODE  = v.mode;
    REQ_CIN   = v.cin;
    REQ_SPLIT = v.split;
    REQ_GAP   = v.gap;
  endtask

  task automatic issue_req(input vec_t v);
    int n = 0;
    while (!REQ_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready_wait", 64'(REQ_READY), 64'd1);
    set_req(v);
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  // Samples once per cycle from ISSUE1 until RSP_VALID.
  task automatic collect(input vec_t v,
                         output int cyc,
                         output int idle,
                         output logic [1:0] iv1,
                         output logic [1:0] iv2,
                         output int bad);
    cyc = 0; idle = 0; iv1 = '0; iv2 = '0; bad = 0;
    while (!RSP_VALID && cyc < 200) begin
      if (INP_VALID != 2'b00) begin
        if (iv1 == 2'b00) iv1 = INP_VALID;
        iv2 = INP_VALID;
        if (INP_VALID[0] && OPA != v.a) bad++;
        if (INP_VALID[1] && OPB != v.b) bad++;
      end else if (CE) begin
        idle++;
      end
      if (CE && (CMD != v.cmd || MODE != v.mode ||
                 CIN != v.cin)) bad++;
      if (REQ_READY) bad++;
      cyc++;
      @(negedge CLK);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, 64'({INP_VALID, OPA, OPB, CMD, MODE,
                   CIN, CE, RSP_VALID, RSP_RES,
                   RSP_FLAGS, RSP_TMO, REQ_READY}),
        64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, idle, bad;
    logic [1:0] iv1, iv2;
    logic [9:0] held;

    vt[0] = mk(0, 0, 1, 0, 0, 200, 100, 0, 10'd44,
               6'b101000, 0, 3, 2, 2'b11, 2'b11);
    vt[1] = mk(1, 3, 0, 0, 0, 8'hF0, 8'h3C, 0, 10'h30,
               6'b001000, 0, 7, 5, 2'b01, 2'b10);
    vt[2] = mk(0, 0, 1, 9, 0, 3, 4, 0, 10'd20,
               6'b000010, 0, 4, 3, 2'b11, 2'b11);
    vt[3] = mk(2, 16, 1, 0, 0, 5, 5, 1, 10'd10,
               6'b000101, 1, 20, 18, 2'b10, 2'b01);
    vt[4] = mk(3, 7, 1, 10, 0, 2, 7, 0, 10'd28,
               6'b000010, 0, 4, 3, 2'b11, 2'b11);
    vt[5] = mk(1, 0, 0, 1, 0, 8'h0F, 8'h30, 0, 10'h3F,
               6'b000010, 0, 4, 2, 2'b01, 2'b10);
    vt[6] = mk(2, 31, 0, 2, 0, 8'hAA, 8'h55, 0, 10'hFF,
               6'b001000, 1, 35, 33, 2'b10, 2'b01);
    vt[7] = mk(0, 0, 0, 9, 0, 3, 4, 0, 10'd0,
               6'b000010, 0, 3, 2, 2'b11, 2'b11);
    vt[8] = mk(1, 15, 1, 0, 1, 1, 1, 0, 10'd3,
               6'b000100, 0, 19, 17, 2'b01, 2'b10);

    // Power-on reset.
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_zero("reset_init");
    RST_N = 1'b1;
    #1;
    chk("ready_after_reset", 64'(REQ_READY), 64'd1);
    @(negedge CLK);

    foreach (vt[i]) begin
      alu_err = vt[i].err;
      issue_req(vt[i]);
      collect(vt[i], cyc, idle, iv1, iv2, bad);
      chk($sformatf("v%0d_cycles", i), 64'(cyc),
          64'(vt[i].cyc));
      chk($sformatf("v%0d_seq", i),
          64'({iv1, iv2, 8'(idle)}),
          64'({vt[i].iv1, vt[i].iv2, 8'(vt[i].idle)}));
      chk($sformatf("v%0d_opnd", i), 64'(bad), 64'd0);
      chk($sformatf("v%0d_res", i), 64'(RSP_RES),
          64'(vt[i].res));
      chk($sformatf("v%0d_flags", i), 64'(RSP_FLAGS),
          64'(vt[i].flags));
      chk($sformatf("v%0d_tmo", i), 64'(RSP_TMO),
          64'(vt[i].tmo));
      chk($sformatf("v%0d_busy", i),
          64'({RSP_VALID, REQ_READY, CE}), 64'b100);
      RSP_READY = 1'b1;
      @(negedge CLK);
      RSP_READY = 1'b0;
      chk($sformatf("v%0d_idle", i),
          64'({RSP_VALID, REQ_READY}), 64'b01);
    end
    alu_err = 1'b0;

    // Backpressure with a second request waiting.
    issue_req(vt[0]);
    collect(vt[0], cyc, idle, iv1, iv2, bad);
    chk("bp_first_cycles", 64'(cyc), 64'd3);
    held = RSP_RES;
    set_req(vt[2]);
    REQ_VALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_stall%0d", k),
          64'({RSP_VALID, REQ_READY, CE, RSP_RES}),
          64'({3'b100, 10'd44}));
      @(negedge CLK);
    end
    chk("bp_res_stable", 64'(RSP_RES), 64'(held));
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    chk("bp_second_ready", 64'(REQ_READY), 64'd1);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    collect(vt[2], cyc, idle, iv1, iv2, bad);
    chk("bp_second_cycles", 64'(cyc), 64'd4);
    chk("bp_second_res", 64'(RSP_RES), 64'd20);
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;

    // Reset in the middle of WAIT abandons the operation.
    issue_req(vt[2]);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_wait_ce", 64'({CE, INP_VALID}), 64'b100);
    RST_N = 1'b0;
    @(negedge CLK);
    check_zero("reset_mid1");
    @(negedge CLK);
    check_zero("reset_mid2");
    RST_N = 1'b1;
    #1;
    chk("ready_after_mid_reset", 64'(REQ_READY), 64'd1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (RSP_VALID || CE || INP_VALID != 2'b00) bad++;
    end
    chk("no_rsp_after_reset", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
